// File: rtl/idli_mem_req_m_if.sv
// rtl/idli_mem_req_m_if.sv - bus bundle between the idli memory request sequencer and its neighbours
//
// Signals (master = sequencer side):
//   sqi_ctr      2   GCK phase counter; one 4-cycle period carries one 16b word
//   sqi_redirect 1   restart SQI transaction at the address on sqi_slice
//   sqi_wr_en    1   current/next SQI transaction is a WRITE
//   sqi_stall    1   hold SQI fetch stream
//   sqi_slice    4   address/store-data nibble towards the SQI interface
//   sqi_data     4   buffered data nibble from the SQI interface
//   br_vld/br_addr               branch redirect request and target
//   ls_vld/ls_wr/ls_addr/ls_data load/store request (ls_wr=1 store)
//   ret_addr     16  fetch address to resume at after a load/store
//   ls_rdy       1   load/store request accepted this cycle
//   ls_done      1   single-cycle load/store completion pulse
//   ld_data      16  last loaded word
//   dec_stall    1   decode cannot accept an instruction
//   busy         1   fetch stream invalid
interface idli_mem_req_m_if;
  logic [1:0]  sqi_ctr;
  logic        sqi_redirect;
  logic        sqi_wr_en;
  logic        sqi_stall;
  logic [3:0]  sqi_slice;
  logic [3:0]  sqi_data;
  logic        br_vld;
  logic [15:0] br_addr;
  logic        ls_vld;
  logic        ls_wr;
  logic [15:0] ls_addr;
  logic [15:0] ls_data;
  logic [15:0] ret_addr;
  logic        ls_rdy;
  logic        ls_done;
  logic [15:0] ld_data;
  logic        dec_stall;
  logic        busy;

  modport master (
    output sqi_ctr, sqi_redirect, sqi_wr_en, sqi_stall, sqi_slice,
    input  sqi_data,
    input  br_vld, br_addr, ls_vld, ls_wr, ls_addr, ls_data, ret_addr,
    output ls_rdy, ls_done, ld_data,
    input  dec_stall,
    output busy
  );

  modport slave (
    input  sqi_ctr, sqi_redirect, sqi_wr_en, sqi_stall, sqi_slice,
    output sqi_data,
    output br_vld, br_addr, ls_vld, ls_wr, ls_addr, ls_data, ret_addr,
    input  ls_rdy, ls_done, ld_data,
    output dec_stall,
    input  busy
  );
endinterface

// File: rtl/idli_mem_req_m.sv
// rtl/idli_mem_req_m.sv - idli memory request sequencer feeding the SQI memory interface
//
// Ports:
//   i_sqi_gck    core clock (GCK)
//   i_sqi_rst_n  asynchronous active-low reset
//   bus          idli_mem_req_m_if.master: SQI control/slice outputs, load/store and
//                branch requests in, ls_rdy/ls_done/ld_data/busy out
module idli_mem_req_m (
  input  logic              i_sqi_gck,
  input  logic              i_sqi_rst_n,
  idli_mem_req_m_if.master  bus
);

  typedef enum logic [2:0] {
    ST_SETUP,
    ST_FETCH,
    ST_REDIR,
    ST_ACCESS,
    ST_RETURN
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  ctr_q;
  logic [2:0]  setup_q, setup_d;
  logic [15:0] addr_q;
  logic [15:0] data_q;
  logic [15:0] ret_q;
  logic [15:0] ld_q;
  logic        wr_q;
  logic        ls_q;        // a load/store is in flight
  logic        last;        // final cycle of a 4-cycle period
  logic [3:0]  nib;         // bit offset of the nibble for this phase
  logic        br_take, ls_take, done;
  logic        redirect;
  logic [3:0]  slice;

  assign last = (ctr_q == 2'd3);
  assign nib  = {ctr_q, 2'b00};

  always_ff @(posedge i_sqi_gck or negedge i_sqi_rst_n) begin
    if (!i_sqi_rst_n) begin
      ctr_q   <= 2'd0;
      state_q <= ST_SETUP;
      setup_q <= 3'd5;
      addr_q  <= 16'h0000;
      data_q  <= 16'h0000;
      ret_q   <= 16'h0000;
      ld_q    <= 16'h0000;
      wr_q    <= 1'b0;
      ls_q    <= 1'b0;
    end else begin
      ctr_q   <= ctr_q + 2'd1;
      state_q <= state_d;
      setup_q <= setup_d;
      if (br_take) begin
        addr_q <= bus.br_addr;
      end else if (ls_take) begin
        addr_q <= bus.ls_addr;
        data_q <= bus.ls_data;
        ret_q  <= bus.ret_addr;
        wr_q   <= bus.ls_wr;
        ls_q   <= 1'b1;
      end
      // Load data streams back during the RETURN period, one nibble per phase.
      if (state_q == ST_RETURN && ls_q && !wr_q) begin
        ld_q[nib +: 4] <= bus.sqi_data;
      end
      if (done) begin
        ls_q <= 1'b0;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    setup_d  = setup_q;
    br_take  = 1'b0;
    ls_take  = 1'b0;
    done     = 1'b0;
    redirect = 1'b0;
    slice    = 4'h0;
    case (state_q)
      ST_SETUP: begin
        // Store data goes out in the last idle period so it lines up with the write.
        if (ls_q && wr_q && setup_q == 3'd1) begin
          slice = data_q[nib +: 4];
        end
        if (last) begin
          setup_d = setup_q - 3'd1;
          if (setup_q == 3'd1) begin
            state_d = ls_q ? ST_ACCESS : ST_FETCH;
          end
        end
      end
      ST_FETCH: begin
        if (last) begin
          if (bus.br_vld) begin
            br_take = 1'b1;
            state_d = ST_REDIR;
          end else if (bus.ls_vld) begin
            ls_take = 1'b1;
            state_d = ST_REDIR;
          end
        end
      end
      ST_REDIR: begin
        redirect = 1'b1;
        slice    = addr_q[nib +: 4];
        if (last) begin
          // Stores skip the DUMMY period.
          setup_d = (ls_q && wr_q) ? 3'd4 : 3'd5;
          state_d = ST_SETUP;
        end
      end
      ST_ACCESS: begin
        if (last) begin
          state_d = ST_RETURN;
        end
      end
      ST_RETURN: begin
        redirect = 1'b1;
        slice    = ret_q[nib +: 4];
        if (last) begin
          done    = 1'b1;
          setup_d = 3'd5;
          state_d = ST_SETUP;
        end
      end
      default: begin
        state_d = ST_SETUP;
      end
    endcase
  end

  assign bus.sqi_ctr      = ctr_q;
  assign bus.sqi_redirect = redirect;
  assign bus.sqi_slice    = slice;
  assign bus.sqi_wr_en    = ls_q && wr_q &&
                            (state_q == ST_REDIR || state_q == ST_SETUP || state_q == ST_ACCESS);
  assign bus.sqi_stall    = bus.dec_stall && (state_q == ST_FETCH);
  assign bus.ls_rdy       = ls_take;
  assign bus.ls_done      = done;
  assign bus.ld_data      = ld_q;
  assign bus.busy         = (state_q != ST_FETCH);

endmodule

// File: tb/tb_idli_mem_req_m.sv
// tb/tb_idli_mem_req_m.sv - self-checking bench for idli_mem_req_m
module tb_idli_mem_req_m;

  localparam int K_BR = 0;
  localparam int K_LD = 1;
  localparam int K_ST = 2;

  typedef struct {
    int          kind;
    logic [15:0] addr;
    logic [15:0] data;
    logic [15:0] ret;
    logic [15:0] rdata;
    logic [15:0] exp_ld;
    int          exp_lat;
    int          exp_busy;
  } vec_t;

  typedef struct {
    logic [15:0] ld;
    int          lat;
  } sb_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  sb_t  sb_q[$];
  vec_t vecs[6];

  always #5 clk = ~clk;

  idli_mem_req_m_if bus();

  idli_mem_req_m dut (
    .i_sqi_gck   (clk),
    .i_sqi_rst_n (rst_n),
    .bus         (bus.master)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_fetch3(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (!bus.busy && bus.sqi_ctr == 2'd3) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) check("fetch_timeout", 0, 1);
  endtask

  task automatic run_vec(input vec_t v);
    bit          ok;
    bit          pend;
    int          n;
    int          done_n;
    int          wr_n;
    int          redir_n;
    int          busy_idx;
    logic [15:0] redir_w;
    logic [15:0] ret_w;
    logic [15:0] st_w;
    sb_t         e;
    wait_fetch3(ok);
    if (!ok) return;
    bus.br_vld   = (v.kind == K_BR);
    bus.br_addr  = v.addr;
    bus.ls_vld   = (v.kind != K_BR);
    bus.ls_wr    = (v.kind == K_ST);
    bus.ls_addr  = v.addr;
    bus.ls_data  = v.data;
    bus.ret_addr = v.ret;
    #1;
    check("ls_rdy", bus.ls_rdy, v.kind != K_BR);
    if (v.kind != K_BR) begin
      e.ld  = v.exp_ld;
      e.lat = v.exp_lat;
      sb_q.push_back(e);
    end
    @(negedge clk);
    bus.br_vld = 1'b0;
    bus.ls_vld = 1'b0;
    pend = 1'b0; done_n = 0; wr_n = 0; redir_n = 0; busy_idx = -1;
    redir_w = 16'h0; ret_w = 16'h0; st_w = 16'h0;
    for (int cyc = 1; cyc <= 100 && busy_idx < 0; cyc++) begin
      n = 4 * int'(bus.sqi_ctr);
      if (pend) begin
        check("ld_data", bus.ld_data, e.ld);
        pend = 1'b0;
      end
      if (bus.sqi_redirect) begin
        if (redir_n < 4) redir_w[n +: 4] = bus.sqi_slice;
        else             ret_w[n +: 4]   = bus.sqi_slice;
        redir_n++;
      end
      if (v.kind == K_ST && cyc > v.exp_lat - 12 && cyc <= v.exp_lat - 8)
        st_w[n +: 4] = bus.sqi_slice;
      if (bus.sqi_wr_en) wr_n++;
      bus.sqi_data = v.rdata[n +: 4];
      if (bus.ls_done) begin
        done_n++;
        if (sb_q.size() == 0) begin
          check("sb_unexpected_done", 1, 0);
        end else begin
          e = sb_q.pop_front();
          check("ls_latency", cyc, e.lat);
          pend = 1'b1;
        end
      end
      if (!bus.busy) busy_idx = cyc;
      else @(negedge clk);
    end
    check("busy_clear_cycle", busy_idx, v.exp_busy);
    check("redirect_cycles", redir_n, (v.kind == K_BR) ? 4 : 8);
    check("redir_addr", redir_w, v.addr);
    check("wr_en_cycles", wr_n, (v.kind == K_ST) ? v.exp_lat - 4 : 0);
    check("done_pulses", done_n, (v.kind == K_BR) ? 0 : 1);
    if (v.kind != K_BR) check("ret_addr", ret_w, v.ret);
    if (v.kind == K_ST) check("store_data", st_w, v.data);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int first_idle;
    int ctr_bad;
    int redir_seen;
    int idx;
    int done_n;

    vecs[0] = '{K_BR, 16'hA5C3, 16'h0000, 16'h0000, 16'h0000, 16'h0000,  0, 25};
    vecs[1] = '{K_LD, 16'h1234, 16'h0000, 16'h0040, 16'hCDEF, 16'hCDEF, 32, 53};
    vecs[2] = '{K_ST, 16'h0008, 16'hBEEF, 16'h1111, 16'h0000, 16'hCDEF, 28, 49};
    vecs[3] = '{K_LD, 16'hFFFF, 16'h0000, 16'hFFFE, 16'h0001, 16'h0001, 32, 53};
    vecs[4] = '{K_ST, 16'h8001, 16'h5A0F, 16'h7FFF, 16'h0000, 16'h0001, 28, 49};
    vecs[5] = '{K_BR, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000,  0, 25};

    bus.sqi_data = 4'h0; bus.br_vld = 1'b0; bus.br_addr = 16'h0;
    bus.ls_vld = 1'b0; bus.ls_wr = 1'b0; bus.ls_addr = 16'h0;
    bus.ls_data = 16'h0; bus.ret_addr = 16'h0; bus.dec_stall = 1'b0;

    repeat (3) @(negedge clk);
    check("rst_ctr", bus.sqi_ctr, 0);
    check("rst_busy", bus.busy, 1);
    check("rst_redirect", bus.sqi_redirect, 0);
    check("rst_wr_en", bus.sqi_wr_en, 0);
    check("rst_stall", bus.sqi_stall, 0);
    check("rst_slice", bus.sqi_slice, 0);
    check("rst_ls_rdy", bus.ls_rdy, 0);
    check("rst_ls_done", bus.ls_done, 0);
    check("rst_ld_data", bus.ld_data, 0);

    // Reset release: 20 GCK of setup, ctr free-running, no redirect.
    rst_n = 1'b1;
    first_idle = -1; ctr_bad = 0; redir_seen = 0;
    for (int i = 0; i <= 24 && first_idle < 0; i++) begin
      if (int'(bus.sqi_ctr) != i % 4) ctr_bad++;
      if (bus.sqi_redirect) redir_seen++;
      if (!bus.busy) first_idle = i;
      else @(negedge clk);
    end
    check("boot_fetch_cycle", first_idle, 20);
    check("boot_ctr_seq_errs", ctr_bad, 0);
    check("boot_redirects", redir_seen, 0);

    for (int i = 0; i < 6; i++) run_vec(vecs[i]);

    // Stall only propagates in FETCH.
    bus.dec_stall = 1'b1;
    #1;
    check("stall_fetch", bus.sqi_stall, 1);
    wait_fetch3(ok);
    bus.br_vld = 1'b1; bus.br_addr = 16'h0100;
    @(negedge clk);
    bus.br_vld = 1'b0;
    check("stall_redir", bus.sqi_stall, 0);
    repeat (8) @(negedge clk);
    check("stall_setup", bus.sqi_stall, 0);
    wait_fetch3(ok);
    check("stall_fetch_again", bus.sqi_stall, 1);
    bus.dec_stall = 1'b0;

    // Branch and load together: branch wins, load accepted at next FETCH ctr==3.
    wait_fetch3(ok);
    bus.br_vld = 1'b1; bus.br_addr = 16'h2222;
    bus.ls_vld = 1'b1; bus.ls_wr = 1'b0; bus.ls_addr = 16'h3333; bus.ret_addr = 16'h4444;
    #1;
    check("both_ls_rdy", bus.ls_rdy, 0);
    @(negedge clk);
    bus.br_vld = 1'b0;
    idx = -1;
    for (int i = 1; i <= 60 && idx < 0; i++) begin
      if (bus.ls_rdy) idx = i;
      else @(negedge clk);
    end
    check("both_ls_accept_cycle", idx, 28);
    @(negedge clk);
    bus.ls_vld = 1'b0;
    idx = -1;
    for (int i = 1; i <= 60 && idx < 0; i++) begin
      if (bus.ls_done) idx = i;
      else @(negedge clk);
    end
    check("both_ls_done_cycle", idx, 32);

    // Reset in the middle of a load drops it silently.
    wait_fetch3(ok);
    bus.ls_vld = 1'b1; bus.ls_wr = 1'b0; bus.ls_addr = 16'h5555; bus.ret_addr = 16'h6666;
    @(negedge clk);
    bus.ls_vld = 1'b0;
    repeat (29) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_busy", bus.busy, 1);
    check("midrst_ctr", bus.sqi_ctr, 0);
    check("midrst_redirect", bus.sqi_redirect, 0);
    check("midrst_ls_done", bus.ls_done, 0);
    check("midrst_ld_data", bus.ld_data, 0);
    @(negedge clk);
    rst_n = 1'b1;
    done_n = 0;
    for (int i = 0; i < 60; i++) begin
      if (bus.ls_done) done_n++;
      @(negedge clk);
    end
    check("midrst_no_done", done_n, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
